irqgen_timed: RTL and testbench
===============================

IRQGEN_TIMED -- requirements
Module: irqgen_timed

Interface
- REQ-001 SHALL have parameter NumIrqs, default 3, meaning number of interrupt lines, legal range 1..32.
- REQ-002 SHALL have parameter CntWidth, default 32, meaning delay counter width, legal range 8..32.
- REQ-003 SHALL have parameter BaseAddr, default 32'h2000, meaning byte address of register 0.
- REQ-004 SHALL have port clk_i, input, 1, meaning the single clock; every register samples on its rising edge.
- REQ-005 SHALL have port rst_i, input, 1, meaning synchronous active-high reset.
- REQ-006 SHALL have port req_i, input, 1, meaning a bus request is present this cycle.
- REQ-007 SHALL have port gnt_o, output, 1, meaning grant; tied to 1.
- REQ-008 SHALL have port addr_i, input, 32, meaning byte address.
- REQ-009 SHALL have port we_i, input, 1, meaning write (1) or read (0).
- REQ-010 SHALL have port wdata_i, input, 32, meaning write data.
- REQ-011 SHALL have port strb_i, input, 32, meaning bitwise write mask.
- REQ-012 SHALL have port rdata_o, output, 32, meaning read data.
- REQ-013 SHALL have port rvalid_o, output, 1, meaning rdata_o is valid this cycle.
- REQ-014 SHALL have port irq_o, output, NumIrqs, meaning level interrupt lines.
- REQ-015 SHALL have port busy_o, output, 1, meaning a countdown is armed.

Function
- REQ-016 SHALL decode the register map at BaseAddr+offset, 8-byte stride: 0x00 STAGE (NumIrqs bits, RW), 0x08 DELAY (CntWidth bits, RW), 0x10 MODE (bit0 periodic, RW), 0x18 COMMIT (WO), 0x20 CLEAR (W1C on irq_o), 0x28 CANCEL (WO), 0x30 STATUS (RO: bit0 busy, bits[8 +: NumIrqs] irq_o).
- REQ-017 SHALL apply writes to STAGE, DELAY and MODE as reg = (reg & ~strb) | (wdata & strb), truncated to the register width.
- REQ-018 SHALL treat a write to COMMIT or CANCEL as effective only if strb_i != 0; wdata_i is ignored.
- REQ-019 SHALL treat a write to CLEAR as clearing irq_o[i] where wdata_i[i] & strb_i[i] = 1.
- REQ-020 SHALL register read responses: a read request in cycle t drives rvalid_o=1 and rdata_o in cycle t+1; rdata_o = 0 with rvalid_o = 0 otherwise.
- REQ-021 SHALL read 0 on register bits above each register width, on write-only registers, and at unmapped addresses.
- REQ-022 SHALL ignore writes to unmapped addresses and to STATUS.
- REQ-023 SHALL implement an FSM with states IDLE and COUNT; busy_o = (state == COUNT).
- REQ-024 SHALL, on an effective COMMIT in cycle t, snapshot STAGE into SHADOW, load cnt = DELAY, and enter COUNT.
- REQ-025 SHALL, in COUNT, decrement cnt when cnt != 0, and fire when cnt == 0; firing sets irq_o |= SHADOW at the next edge.
- REQ-026 SHALL produce the fire latency: irq_o visible at cycle t+DELAY+1; DELAY=0 gives t+1.
- REQ-027 SHALL, on fire with MODE.periodic=0, return to IDLE; with periodic=1, reload cnt = DELAY (current value) and stay in COUNT, giving a period of DELAY+1 cycles.
- REQ-028 SHALL, on a COMMIT while in COUNT, restart: re-snapshot SHADOW and reload cnt, with no fire from the old countdown.
- REQ-029 SHALL, on CANCEL, go to IDLE without firing and leave irq_o unchanged; COMMIT and CANCEL in the same cycle is impossible (single port).
- REQ-030 SHALL give set priority when a fire and a CLEAR hit the same bit in the same cycle: the bit ends at 1.
- REQ-031 SHALL NOT restart a countdown on writes to STAGE or DELAY during COUNT; only a later COMMIT or periodic reload observes them.
- REQ-032 SHALL NOT have cnt wrap: it saturates at 0 and holds there only until the fire.

Reset
- REQ-033 SHALL, while rst_i=1 at an edge, clear STAGE, DELAY, MODE, SHADOW, cnt, irq_o, rdata_o and rvalid_o to 0 and set state to IDLE, abandoning any countdown or pending read.
- REQ-034 SHALL hold gnt_o=1 during reset; bus requests during reset are dropped.

Verification
- REQ-035 SHALL have a bench cover: STAGE=3'b101, DELAY=4, COMMIT at cycle t -> irq_o=3'b101 from t+5, busy_o=0 from t+5; CLEAR wdata=1 -> irq_o=3'b100.
- REQ-036 SHALL have a bench cover: DELAY=0, STAGE=3'b010, COMMIT at t -> irq_o=3'b010 at t+1.
- REQ-037 SHALL have a bench cover: MODE=1, DELAY=2, STAGE=1, COMMIT at t, CLEAR after each fire -> irq_o[0] rises at t+3, t+6, t+9; CANCEL -> busy_o=0 and no further fires.
- REQ-038 SHALL have a bench cover: COMMIT at t with DELAY=10, then STAGE=3'b100 and COMMIT at t+5 -> single fire of 3'b100 at t+16, none at t+11.
- REQ-039 SHALL have a bench cover: a fire coincides with CLEAR of the same bit -> the bit stays 1; a strb_i=0 write to DELAY -> DELAY unchanged.
- REQ-040 SHALL have a bench cover: rst_i=1 asserted mid-countdown -> next cycle irq_o=0, busy_o=0, and a STATUS read returns 0.

Source files
------------

// File: rtl/irqgen_timed.sv
// Register-programmed interrupt generator: a COMMIT snapshots STAGE and, DELAY+1
// cycles later, raises those irq_o lines (once, or every DELAY+1 cycles when periodic).
module irqgen_timed #(
    parameter int          NumIrqs  = 3,
    parameter int          CntWidth = 32,
    parameter logic [31:0] BaseAddr = 32'h2000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_i,
    output logic               gnt_o,
    input  logic [31:0]        addr_i,
    input  logic               we_i,
    input  logic [31:0]        wdata_i,
    input  logic [31:0]        strb_i,
    output logic [31:0]        rdata_o,
    output logic               rvalid_o,
    output logic [NumIrqs-1:0] irq_o,
    output logic               busy_o
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_COUNT = 1'b1;

    localparam logic [2:0] REG_STAGE  = 3'd0;
    localparam logic [2:0] REG_DELAY  = 3'd1;
    localparam logic [2:0] REG_MODE   = 3'd2;
    localparam logic [2:0] REG_COMMIT = 3'd3;
    localparam logic [2:0] REG_CLEAR  = 3'd4;
    localparam logic [2:0] REG_CANCEL = 3'd5;
    localparam logic [2:0] REG_STATUS = 3'd6;

    // STATUS carries irq_o from bit 8 upward; lines that do not fit in 32 bits are not shown.
    localparam int StatIrqs = (NumIrqs < 24) ? NumIrqs : 24;

    logic [0:0]          r_state;
    logic [NumIrqs-1:0]  r_stage;
    logic [NumIrqs-1:0]  r_shadow;
    logic [NumIrqs-1:0]  r_irq;
    logic [CntWidth-1:0] r_delay;
    logic [CntWidth-1:0] r_cnt;
    logic                r_mode;
    logic [31:0]         r_rdata;
    logic                r_rvalid;

    logic [31:0]         w_offset;
    logic [2:0]          w_idx;
    logic                w_mapped;
    logic                w_wr;
    logic                w_rd;
    logic                w_wr_stage;
    logic                w_wr_delay;
    logic                w_wr_mode;
    logic                w_wr_clear;
    logic                w_commit;
    logic                w_cancel;
    logic                w_fire;
    logic [NumIrqs-1:0]  w_clr;
    logic [NumIrqs-1:0]  w_set;
    logic [31:0]         w_rdata;

    assign w_offset = addr_i - BaseAddr;
    assign w_idx    = w_offset[5:3];
    assign w_mapped = (w_offset[31:6] == '0) && (w_offset[2:0] == 3'd0) && (w_idx != 3'd7);

    assign w_wr       = req_i && we_i && w_mapped;
    assign w_rd       = req_i && !we_i;
    assign w_wr_stage = w_wr && (w_idx == REG_STAGE);
    assign w_wr_delay = w_wr && (w_idx == REG_DELAY);
    assign w_wr_mode  = w_wr && (w_idx == REG_MODE);
    assign w_wr_clear = w_wr && (w_idx == REG_CLEAR);
    assign w_commit   = w_wr && (w_idx == REG_COMMIT) && (strb_i != '0);
    assign w_cancel   = w_wr && (w_idx == REG_CANCEL) && (strb_i != '0);

    // A COMMIT or CANCEL landing on the due cycle pre-empts the old countdown's fire.
    assign w_fire = (r_state == ST_COUNT) && (r_cnt == '0) && !w_commit && !w_cancel;
    assign w_clr  = w_wr_clear ? (wdata_i[NumIrqs-1:0] & strb_i[NumIrqs-1:0]) : '0;
    assign w_set  = w_fire ? r_shadow : '0;

    always_comb begin
        w_rdata = '0;
        if (w_mapped) begin
            case (w_idx)
                REG_STAGE:  w_rdata[NumIrqs-1:0]  = r_stage;
                REG_DELAY:  w_rdata[CntWidth-1:0] = r_delay;
                REG_MODE:   w_rdata[0]            = r_mode;
                REG_STATUS: begin
                    w_rdata[0]             = (r_state == ST_COUNT);
                    w_rdata[8 +: StatIrqs] = r_irq[StatIrqs-1:0];
                end
                default:    w_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_stage  <= '0;
            r_shadow <= '0;
            r_irq    <= '0;
            r_delay  <= '0;
            r_cnt    <= '0;
            r_mode   <= 1'b0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_rd;
            r_rdata  <= w_rd ? w_rdata : '0;

            if (w_wr_stage) begin
                r_stage <= (r_stage & ~strb_i[NumIrqs-1:0]) | (wdata_i[NumIrqs-1:0] & strb_i[NumIrqs-1:0]);
            end
            if (w_wr_delay) begin
                r_delay <= (r_delay & ~strb_i[CntWidth-1:0]) | (wdata_i[CntWidth-1:0] & strb_i[CntWidth-1:0]);
            end
            if (w_wr_mode) begin
                r_mode <= (r_mode & ~strb_i[0]) | (wdata_i[0] & strb_i[0]);
            end

            // Set wins over clear when both touch the same line.
            r_irq <= (r_irq & ~w_clr) | w_set;

            if (w_commit) begin
                r_shadow <= r_stage;
                r_cnt    <= r_delay;
                r_state  <= ST_COUNT;
            end else if (w_cancel) begin
                r_state <= ST_IDLE;
            end else if (r_state == ST_COUNT) begin
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - CntWidth'(1);
                end else if (r_mode) begin
                    r_cnt <= r_delay;
                end else begin
                    r_state <= ST_IDLE;
                end
            end
        end
    end

    assign gnt_o    = 1'b1;
    assign rdata_o  = r_rdata;
    assign rvalid_o = r_rvalid;
    assign irq_o    = r_irq;
    assign busy_o   = (r_state == ST_COUNT);

endmodule

// File: tb/tb_irqgen_timed.sv
// Bench for irqgen_timed: directed scenarios plus random bus traffic, checked
// against an event-time reference model; read data goes through a scoreboard queue.
module tb_irqgen_timed;

    localparam int          N        = 3;
    localparam logic [31:0] BASE     = 32'h2000;
    localparam logic [31:0] O_STAGE  = 32'h00;
    localparam logic [31:0] O_DELAY  = 32'h08;
    localparam logic [31:0] O_MODE   = 32'h10;
    localparam logic [31:0] O_COMMIT = 32'h18;
    localparam logic [31:0] O_CLEAR  = 32'h20;
    localparam logic [31:0] O_CANCEL = 32'h28;
    localparam logic [31:0] O_STATUS = 32'h30;
    localparam logic [31:0] ALL      = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req = 1'b0;
    logic          we = 1'b0;
    logic [31:0]   addr = '0;
    logic [31:0]   wdata = '0;
    logic [31:0]   strb = '0;
    logic          gnt_o;
    logic [31:0]   rdata_o;
    logic          rvalid_o;
    logic [N-1:0]  irq_o;
    logic          busy_o;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    // Reference model: a countdown is an absolute edge number at which it fires.
    logic [N-1:0] m_stage  = '0;
    logic [N-1:0] m_shadow = '0;
    logic [N-1:0] m_irq    = '0;
    logic [31:0]  m_delay  = '0;
    logic         m_mode   = 1'b0;
    logic         m_busy   = 1'b0;
    longint       m_fire_at = 0;
    longint       edge_n    = 0;

    irqgen_timed #(.NumIrqs(N), .CntWidth(32), .BaseAddr(BASE)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .req_i    (req),
        .gnt_o    (gnt_o),
        .addr_i   (addr),
        .we_i     (we),
        .wdata_i  (wdata),
        .strb_i   (strb),
        .rdata_o  (rdata_o),
        .rvalid_o (rvalid_o),
        .irq_o    (irq_o),
        .busy_o   (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] r;
        r = '0;
        case (a - BASE)
            O_STAGE:  r[N-1:0] = m_stage;
            O_DELAY:  r = m_delay;
            O_MODE:   r[0] = m_mode;
            O_STATUS: begin
                r[0]     = m_busy;
                r[8 +: N] = m_irq;
            end
            default:  r = '0;
        endcase
        return r;
    endfunction

    task automatic model_edge();
        logic         fire;
        logic         commit;
        logic         cancel;
        logic [N-1:0] clr;
        logic [N-1:0] old_stage;
        logic [N-1:0] old_shadow;
        logic [31:0]  old_delay;
        logic         old_mode;
        edge_n++;
        if (rst) begin
            m_stage = '0; m_shadow = '0; m_irq = '0; m_delay = '0;
            m_mode = 1'b0; m_busy = 1'b0;
            return;
        end
        if (req && !we) exp_q.push_back(model_read(addr));
        old_stage  = m_stage;
        old_shadow = m_shadow;
        old_delay  = m_delay;
        old_mode   = m_mode;
        fire   = m_busy && (edge_n == m_fire_at);
        commit = 1'b0;
        cancel = 1'b0;
        clr    = '0;
        if (req && we) begin
            case (addr - BASE)
                O_STAGE:  m_stage = (m_stage & ~strb[N-1:0]) | (wdata[N-1:0] & strb[N-1:0]);
                O_DELAY:  m_delay = (m_delay & ~strb) | (wdata & strb);
                O_MODE:   m_mode  = (m_mode & ~strb[0]) | (wdata[0] & strb[0]);
                O_COMMIT: commit  = (strb != 0);
                O_CLEAR:  clr     = wdata[N-1:0] & strb[N-1:0];
                O_CANCEL: cancel  = (strb != 0);
                default:  ;
            endcase
        end
        if (commit) begin
            m_shadow  = old_stage;
            m_busy    = 1'b1;
            m_fire_at = edge_n + longint'(old_delay) + 1;
            fire      = 1'b0;
        end else if (cancel) begin
            m_busy = 1'b0;
            fire   = 1'b0;
        end
        m_irq = (m_irq & ~clr) | (fire ? old_shadow : '0);
        if (fire) begin
            if (old_mode) m_fire_at = edge_n + longint'(old_delay) + 1;
            else          m_busy = 1'b0;
        end
    endtask

    task automatic cycle(input logic i_rst, input logic i_req, input logic i_we,
                         input logic [31:0] i_addr, input logic [31:0] i_wdata,
                         input logic [31:0] i_strb);
        logic rd_now;
        rst = i_rst; req = i_req; we = i_we; addr = i_addr; wdata = i_wdata; strb = i_strb;
        rd_now = !i_rst && i_req && !i_we;
        @(posedge clk);
        model_edge();
        #1;
        chk("irq", {29'd0, irq_o}, {29'd0, m_irq});
        chk("busy", {31'd0, busy_o}, {31'd0, m_busy});
        chk("rvalid_lat", {31'd0, rvalid_o}, {31'd0, rd_now});
        chk("gnt", {31'd0, gnt_o}, 32'd1);
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        cycle(1'b0, 1'b1, 1'b1, BASE + off, d, ALL);
    endtask

    task automatic rd(input logic [31:0] off);
        cycle(1'b0, 1'b1, 1'b0, BASE + off, 32'd0, 32'd0);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    endtask

    // Read-data monitor, decoupled from stimulus.
    initial begin
        forever begin
            @(negedge clk);
            if (rvalid_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rdata_unexpected: got %h with no read outstanding", rdata_o);
                end else begin
                    chk("rdata", rdata_o, exp_q.pop_front());
                end
            end else begin
                chk("rdata_idle", rdata_o, 32'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        cycle(1'b1, 1'b1, 1'b0, BASE + O_STATUS, 32'd0, 32'd0);
        chk("rst_irq", {29'd0, irq_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        rd(O_STAGE); rd(O_DELAY); rd(O_MODE); rd(O_STATUS);

        // One-shot, DELAY=4
        wr(O_STAGE, 32'd5); wr(O_DELAY, 32'd4); wr(O_MODE, 32'd0);
        wr(O_COMMIT, 32'd0);
        chk("d4_busy", {31'd0, busy_o}, 32'd1);
        for (int i = 1; i <= 4; i++) begin
            idle();
            chk("d4_early", {29'd0, irq_o}, 32'd0);
        end
        idle();
        chk("d4_fire", {29'd0, irq_o}, 32'd5);
        chk("d4_done", {31'd0, busy_o}, 32'd0);
        rd(O_STATUS);
        wr(O_CLEAR, 32'd1);
        chk("d4_clear", {29'd0, irq_o}, 32'd4);
        wr(O_CLEAR, 32'd7);

        // DELAY=0
        wr(O_DELAY, 32'd0); wr(O_STAGE, 32'd2); wr(O_COMMIT, 32'd1);
        chk("d0_t", {29'd0, irq_o}, 32'd0);
        idle();
        chk("d0_t1", {29'd0, irq_o}, 32'd2);
        wr(O_CLEAR, 32'd7);

        // Periodic, DELAY=2
        wr(O_MODE, 32'd1); wr(O_DELAY, 32'd2); wr(O_STAGE, 32'd1); wr(O_COMMIT, 32'd1);
        for (int p = 0; p < 3; p++) begin
            if (p == 0) idle(); else wr(O_CLEAR, 32'd1);
            chk("per_gap", {29'd0, irq_o}, 32'd0);
            idle();
            chk("per_gap", {29'd0, irq_o}, 32'd0);
            idle();
            chk("per_fire", {29'd0, irq_o}, 32'd1);
        end
        wr(O_CANCEL, 32'd0);
        chk("per_cancel_busy", {31'd0, busy_o}, 32'd0);
        chk("per_cancel_keep", {29'd0, irq_o}, 32'd1);
        wr(O_CLEAR, 32'd1);
        for (int i = 0; i < 8; i++) begin
            idle();
            chk("per_nofire", {29'd0, irq_o}, 32'd0);
        end
        wr(O_MODE, 32'd0);

        // Restart mid-countdown
        wr(O_STAGE, 32'd1); wr(O_DELAY, 32'd10); wr(O_COMMIT, 32'd1);
        for (int i = 0; i < 3; i++) idle();
        wr(O_STAGE, 32'd4);
        wr(O_COMMIT, 32'd1);
        for (int i = 0; i < 10; i++) begin
            idle();
            chk("restart_quiet", {29'd0, irq_o}, 32'd0);
        end
        idle();
        chk("restart_fire", {29'd0, irq_o}, 32'd4);
        chk("restart_done", {31'd0, busy_o}, 32'd0);
        wr(O_CLEAR, 32'd7);

        // Fire and CLEAR on the same line in the same cycle
        wr(O_STAGE, 32'd1); wr(O_DELAY, 32'd1); wr(O_COMMIT, 32'd1);
        idle(); idle();
        chk("pre_set", {29'd0, irq_o}, 32'd1);
        wr(O_COMMIT, 32'd1);
        idle();
        wr(O_CLEAR, 32'd1);
        chk("set_priority", {29'd0, irq_o}, 32'd1);
        wr(O_CLEAR, 32'd1);
        chk("clear_after", {29'd0, irq_o}, 32'd0);
        cycle(1'b0, 1'b1, 1'b1, BASE + O_DELAY, 32'hDEAD_BEEF, 32'd0);
        rd(O_DELAY);
        cycle(1'b0, 1'b1, 1'b1, BASE + O_COMMIT, 32'd1, 32'd0);
        chk("commit_nostrb", {31'd0, busy_o}, 32'd0);

        // Reset mid-countdown
        wr(O_STAGE, 32'd7); wr(O_DELAY, 32'd2); wr(O_MODE, 32'd1); wr(O_COMMIT, 32'd1);
        for (int i = 0; i < 4; i++) idle();
        chk("pre_rst_irq", {29'd0, irq_o}, 32'd7);
        cycle(1'b1, 1'b1, 1'b0, BASE + O_STATUS, 32'd0, 32'd0);
        chk("rst_mid_irq", {29'd0, irq_o}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy_o}, 32'd0);
        rd(O_STATUS);
        idle();

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            int          sel;
            int          k;
            logic [31:0] a;
            logic [31:0] d;
            logic [31:0] s;
            sel = $urandom_range(0, 9);
            if (sel <= 6)      a = BASE + 32'(sel * 8);
            else if (sel == 7) a = BASE + 32'h38;
            else if (sel == 8) a = BASE + 32'h4;
            else               a = $urandom;
            if (sel == 1) d = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 12));
            else          d = $urandom;
            k = $urandom_range(0, 9);
            if (k <= 6)      s = ALL;
            else if (k <= 8) s = $urandom;
            else             s = 32'd0;
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7),
                  $urandom_range(0, 1) == 1, a, d, s);
        end

        idle(); idle(); idle();
        chk("rd_drain", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
